// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES-128 round-key sequencer.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS    = 10;
    localparam int unsigned KCNT_W        = 4;
    localparam int unsigned BYTES_PER_KEY = 16;
    localparam int unsigned BCNT_W        = 4;
    localparam int unsigned KEY_W         = 128;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STREAM = 2'd2
    } ks_state_e;

endpackage

// File: rtl/key_sched_ctrl_if.sv
// Control, key-expander and byte-stream signals of the round-key sequencer.
interface key_sched_ctrl_if #(
    parameter int unsigned KCNT_W = aes_pkg::KCNT_W
);

    logic                          start;
    logic                          dec;
    logic                          abort;
    logic                          ke_en;
    logic [KCNT_W-1:0]             ke_kcnt;
    logic                          ke_done;
    logic [aes_pkg::KEY_W-1:0]     ke_wdata;
    logic                          out_valid;
    logic                          out_ready;
    logic [aes_pkg::BYTE_W-1:0]    out_byte;
    logic [KCNT_W-1:0]             out_round;
    logic                          out_last;
    logic                          busy;
    logic                          done;

    // Sequencer side
    modport master (
        input  start, dec, abort, ke_done, ke_wdata, out_ready,
        output ke_en, ke_kcnt, out_valid, out_byte, out_round, out_last, busy, done
    );

    // Environment side: requester, key expander and byte sink
    modport slave (
        output start, dec, abort, ke_done, ke_wdata, out_ready,
        input  ke_en, ke_kcnt, out_valid, out_byte, out_round, out_last, busy, done
    );

endinterface

// File: rtl/key_byte_buf.sv
// 128-bit round-key buffer: parallel load, shift left by one byte, MSB byte out.
module key_byte_buf
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [KEY_W-1:0]  i_data,
    output logic [BYTE_W-1:0] o_byte
);

    logic [KEY_W-1:0] r_buf;

    // Clear beats load beats shift; zero fill keeps the byte output at 0 once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (i_clear) begin
            r_buf <= '0;
        end else if (i_load) begin
            r_buf <= i_data;
        end else if (i_shift) begin
            r_buf <= {r_buf[KEY_W-BYTE_W-1:0], BYTE_W'(0)};
        end
    end

    assign o_byte = r_buf[KEY_W-1 -: BYTE_W];

endmodule

// File: rtl/key_sched_ctrl.sv
// Round-key sequencer: requests each round key from the expander and streams it byte-serially.
module key_sched_ctrl #(
    parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int unsigned KCNT_W     = aes_pkg::KCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    key_sched_ctrl_if.master  bus
);

    import aes_pkg::ks_state_e;
    import aes_pkg::ST_IDLE;
    import aes_pkg::ST_REQ;
    import aes_pkg::ST_STREAM;

    localparam int unsigned BCNT_W = aes_pkg::BCNT_W;
    localparam int unsigned BYTE_W = aes_pkg::BYTE_W;

    localparam logic [KCNT_W-1:0] KCNT_LAST = KCNT_W'(NUM_ROUNDS);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(aes_pkg::BYTES_PER_KEY - 1);
    localparam logic [BCNT_W-1:0] BCNT_PRE  = BCNT_W'(aes_pkg::BYTES_PER_KEY - 2);

    ks_state_e         r_state,     w_state;
    logic              r_dec,       w_dec;
    logic [KCNT_W-1:0] r_kcnt,      w_kcnt;
    logic [KCNT_W-1:0] r_out_round, w_out_round;
    logic [BCNT_W-1:0] r_bcnt,      w_bcnt;
    logic              r_ke_en,     w_ke_en;
    logic              r_out_valid, w_out_valid;
    logic              r_out_last,  w_out_last;
    logic              r_busy,      w_busy;
    logic              r_done,      w_done;

    logic              w_hs;
    logic              w_final;
    logic              w_buf_clear;
    logic              w_buf_load;
    logic              w_buf_shift;
    logic [BYTE_W-1:0] w_byte;

    assign w_hs    = r_out_valid && bus.out_ready;
    assign w_final = r_dec ? (r_kcnt == '0) : (r_kcnt == KCNT_LAST);

    key_byte_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_buf_clear),
        .i_load  (w_buf_load),
        .i_shift (w_buf_shift),
        .i_data  (bus.ke_wdata),
        .o_byte  (w_byte)
    );

    // Next-state and next-output decode; abort overrides everything
    always_comb begin
        w_state     = r_state;
        w_dec       = r_dec;
        w_kcnt      = r_kcnt;
        w_out_round = r_out_round;
        w_bcnt      = r_bcnt;
        w_ke_en     = r_ke_en;
        w_out_valid = r_out_valid;
        w_out_last  = r_out_last;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_buf_clear = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_shift = 1'b0;

        if (bus.abort) begin
            w_state     = ST_IDLE;
            w_dec       = 1'b0;
            w_kcnt      = '0;
            w_out_round = '0;
            w_bcnt      = '0;
            w_ke_en     = 1'b0;
            w_out_valid = 1'b0;
            w_out_last  = 1'b0;
            w_busy      = 1'b0;
            w_buf_clear = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_dec   = bus.dec;
                        w_kcnt  = bus.dec ? KCNT_LAST : '0;
                        w_ke_en = 1'b1;
                        w_busy  = 1'b1;
                        w_state = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.ke_done) begin
                        w_buf_load  = 1'b1;
                        w_bcnt      = '0;
                        w_out_round = r_kcnt;
                        w_ke_en     = 1'b0;
                        w_out_valid = 1'b1;
                        w_out_last  = 1'b0;
                        w_state     = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_hs) begin
                        w_buf_shift = 1'b1;
                        w_bcnt      = BCNT_W'(r_bcnt + 1'b1);
                        w_out_last  = (r_bcnt == BCNT_PRE) && w_final;
                        if (r_bcnt == BCNT_LAST) begin
                            w_out_valid = 1'b0;
                            w_out_last  = 1'b0;
                            if (w_final) begin
                                w_done      = 1'b1;
                                w_busy      = 1'b0;
                                w_kcnt      = '0;
                                w_out_round = '0;
                                w_state     = ST_IDLE;
                            end else begin
                                w_kcnt  = r_dec ? KCNT_W'(r_kcnt - 1'b1) : KCNT_W'(r_kcnt + 1'b1);
                                w_ke_en = 1'b1;
                                w_state = ST_REQ;
                            end
                        end
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dec       <= 1'b0;
            r_kcnt      <= '0;
            r_out_round <= '0;
            r_bcnt      <= '0;
            r_ke_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_dec       <= w_dec;
            r_kcnt      <= w_kcnt;
            r_out_round <= w_out_round;
            r_bcnt      <= w_bcnt;
            r_ke_en     <= w_ke_en;
            r_out_valid <= w_out_valid;
            r_out_last  <= w_out_last;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign bus.ke_en     = r_ke_en;
    assign bus.ke_kcnt   = r_kcnt;
    assign bus.out_valid = r_out_valid;
    assign bus.out_byte  = w_byte;
    assign bus.out_round = r_out_round;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Sequencer for the AES-128 round-key path. It drives the iterative key expander one round at a time (`ke_en`/`ke_kcnt`), captures each 128-bit round key on `ke_done`, and streams it MSB-byte-first to the byte-serial AES datapath through a valid/ready handshake. Encrypt order is rounds 0..10; decrypt order is 10..0. It sits between `key_exp` and the round datapath and replaces ad-hoc register-plus-serializer glue.

## Interface
Parameters:
- `NUM_ROUNDS`, 10: last round index; round keys are `0..NUM_ROUNDS`.
- `KCNT_W`, 4: width of the round index.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a schedule; honoured only in IDLE.
- `dec` in 1: order select, sampled with `start`; 0 = ascending, 1 = descending.
- `abort` in 1: synchronous cancel, returns to IDLE.
- `ke_en` out 1: request to key expander.
- `ke_kcnt` out KCNT_W: round index requested.
- `ke_done` in 1: one-cycle pulse; `ke_wdata` valid in the same cycle.
- `ke_wdata` in 128: round key, byte 0 in [127:120].
- `out_valid` out 1: `out_byte` holds a valid key byte.
- `out_ready` in 1: sink accepts the byte.
- `out_byte` out 8: current key byte.
- `out_round` out KCNT_W: round index of `out_byte`.
- `out_last` out 1: high with byte 15 of the final round.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the final byte is accepted.

## Operation
- States: IDLE, REQ, STREAM.
- IDLE:
  - On `start` (and no `abort`): latch `dec`.
  - Set `ke_kcnt` to 0, or to NUM_ROUNDS when `dec`=1.
  - Enter REQ.
  - `start` outside IDLE is ignored.
- REQ:
  - `ke_en`=1; `ke_kcnt` is held stable.
  - On `ke_done`: load `ke_wdata` into the byte buffer, clear the byte counter, set `out_round`=`ke_kcnt`, drop `ke_en`, enter STREAM.
  - `ke_done` in any other state is ignored.
- STREAM:
  - `out_valid`=1; `out_byte` = buffer[127:120].
  - On `out_valid && out_ready`: shift the buffer left by 8 and increment the 4-bit byte counter.
  - When byte 15 is accepted:
    - If this is the final round (10 ascending, 0 descending): pulse `done`, enter IDLE.
    - Otherwise: step `ke_kcnt` by ±1 and enter REQ.
- `out_last` = STREAM && counter==15 && final round.
- While `out_ready`=0: `out_byte`, `out_round` and `out_last` are held.
- `abort` in any state: next cycle is IDLE with all outputs at reset values. No `done`.
  - `abort` with `start` in the same cycle: `abort` wins.
  - `abort` with a handshake in the same cycle: the byte counts as delivered to the sink, but the stream ends.
- The round index never leaves `0..NUM_ROUNDS`; there is no wrap.

## Timing
- Reset values: `ke_en`, `ke_kcnt`, `out_valid`, `out_byte`, `out_round`, `out_last`, `busy` and `done` are all 0.
- All outputs are registered.
- `start` at edge N: `busy`=1 and `ke_en`=1 from N+1.
- `ke_done` at edge M: `out_valid`=1, first byte, and `ke_en`=0 from M+1.
- With `out_ready` held at 1: one byte per cycle, 16 cycles per round.
- Round gap: byte 15 accepted at edge K → `ke_en`=1 at K+1.
- `done` is high in cycle K+1 after the final accept; `busy` is 0 in that same cycle.
- Total for 11 rounds with 1-cycle expander latency and a constantly ready sink: 11×(16+2) cycles.
- Async reset mid-operation: immediate return to IDLE at reset values; the key expander receives no further requests.

## Structure
- The shared package `aes_pkg` holds:
  - `NUM_ROUNDS`, `KCNT_W`, `BYTES_PER_KEY`=16.
  - The state encoding (IDLE/REQ/STREAM).
- One sub-module, `key_byte_buf`: 128-bit register with parallel load, shift-left-by-8 enable, and `[127:120]` byte output. It uses the same `clk`/`rst_n`.
- FSM, round counter and byte counter live in `key_sched_ctrl`.

## Test plan
- Encrypt stream, with the bench wrapping the real `key_exp`:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, `start`, `dec`=0, `out_ready`=1.
  - Required response: 176 bytes. Round 0 = the key itself; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. `out_last` and `done` are correct; `busy` falls with `done`.
- Decrypt order:
  - Stimulus: same key, `dec`=1.
  - Required response: first 16 bytes d0 14 f9 … a6 with `out_round`=10; last round 0 ends with byte 3c plus `out_last`.
- Backpressure:
  - Stimulus: `out_ready` driven by a random 30% duty pattern.
  - Required response: byte sequence identical to the first test; `out_byte` stable while stalled; no byte lost or duplicated.
- Abort and ignored start:
  - Stimulus: `abort` during round 3, byte 7.
  - Required response: next cycle IDLE, all outputs 0, no `done`.
  - Stimulus: `start` while busy.
  - Required response: no effect on the stream.
- Spurious done:
  - Stimulus: `ke_done` pulsed in IDLE and in STREAM.
  - Required response: buffer and state unchanged.
- Async reset:
  - Stimulus: `rst_n` low mid-STREAM.
  - Required response: outputs 0 immediately; after release, a fresh `start` reproduces the first test exactly.
